// File: rtl/ahb_slave_sram.sv
// ahb_slave_sram - AHB-Lite slave terminating one interconnect port with a
// word-organised SRAM array.
//
// Optional feature macro: AHB_SLAVE_SRAM_ERR_EN
//   defined   : illegal accesses (out of range, oversize, misaligned) get the
//               two-cycle ERROR response and never write.
//   undefined : no checks, HRESP_o tied 0, word index wraps modulo MEM_DEPTH,
//               misaligned accesses use the shifted lane mask as-is.
//
// Ports
//   HCLK         bus clock, rising edge
//   HRESET       asynchronous active-high reset
//   HSEL_i       slave select
//   HTRANS_i     IDLE/BUSY/NONSEQ/SEQ
//   HSIZE_i      transfer size (log2 bytes)
//   HWRITE_i     1 = write
//   HADDR_i      byte address
//   HWDATA_i     write data (data phase)
//   HREADY_i     bus-level ready
//   HRDATA_o     read data (zero outside a read data phase)
//   HREADYOUT_o  this slave's ready
//   HRESP_o      0 = OKAY, 1 = ERROR
//
// state | meaning
// IDLE  | no data phase in progress, ready
// WAIT  | OKAY data phase, inserting wait states
// LAST  | final OKAY data phase cycle, write commits at its closing edge
// ERR1  | first ERROR cycle (not ready)
// ERR2  | second ERROR cycle (ready)
module ahb_slave_sram #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   HSEL_i,
  input  logic [1:0]             HTRANS_i,
  input  logic [2:0]             HSIZE_i,
  input  logic                   HWRITE_i,
  input  logic [HADDR_WIDTH-1:0] HADDR_i,
  input  logic [HDATA_WIDTH-1:0] HWDATA_i,
  input  logic                   HREADY_i,
  output logic [HDATA_WIDTH-1:0] HRDATA_o,
  output logic                   HREADYOUT_o,
  output logic                   HRESP_o
);

  localparam int NBYTES   = HDATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
`ifdef AHB_SLAVE_SRAM_ERR_EN
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;
`endif

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [NBYTES-1:0] lanes_q, lanes_d;
  logic              write_q, write_d;

  logic              accept;
  logic [IDX_W-1:0]  ap_word;
  logic [7:0]        lane_base;
  logic [7:0]        lane_shift;
  logic [NBYTES-1:0] ap_lanes;
  logic              unused_in;

  logic [HDATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign accept = HSEL_i & HTRANS_i[1] & HREADY_i;

  // Low index bits only; with checks enabled the range test below guarantees
  // these are the whole index, without checks this is the modulo wrap.
  assign ap_word = HADDR_i[ADDR_LSB +: IDX_W];

  always_comb begin
    lane_base = 8'hFF;
    case (HSIZE_i)
      3'd0:    lane_base = 8'h01;
      3'd1:    lane_base = 8'h03;
      3'd2:    lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
  end

  // Shift within 8 bits, then keep only the lanes that exist on this bus.
  assign lane_shift = lane_base << HADDR_i[ADDR_LSB-1:0];
  assign ap_lanes   = lane_shift[NBYTES-1:0];

  assign unused_in = ^{HTRANS_i[0], HADDR_i, lane_shift};

`ifdef AHB_SLAVE_SRAM_ERR_EN
  localparam logic [HADDR_WIDTH:0] DEPTH_L = (HADDR_WIDTH + 1)'(MEM_DEPTH);
  logic [HADDR_WIDTH-1:0] idx_full;
  logic [2:0]             align_mask;
  logic                   illegal;

  assign idx_full = HADDR_i >> ADDR_LSB;

  always_comb begin
    align_mask = 3'b111;
    case (HSIZE_i)
      3'd0:    align_mask = 3'b000;
      3'd1:    align_mask = 3'b001;
      3'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign illegal = ({1'b0, idx_full} >= DEPTH_L)
                 | (HSIZE_i > 3'(ADDR_LSB))
                 | (|(HADDR_i[2:0] & align_mask));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    lanes_d = lanes_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_LAST;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef AHB_SLAVE_SRAM_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: begin
        // IDLE, LAST and ERR2 are all ready cycles and dispatch identically.
        state_d = ST_IDLE;
        if (accept) begin
          word_d  = ap_word;
          lanes_d = ap_lanes;
          write_d = HWRITE_i;
`ifdef AHB_SLAVE_SRAM_ERR_EN
          if (illegal) begin
            state_d = ST_ERR1;
          end else
`endif
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_LAST;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      lanes_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      lanes_q <= lanes_d;
      write_q <= write_d;
    end
  end

  // Array is not reset; HRESET only blocks a commit that coincides with it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == ST_LAST) && write_q) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (lanes_q[b]) mem[word_q][8*b +: 8] <= HWDATA_i[8*b +: 8];
      end
    end
  end

  assign HRDATA_o = (((state_q == ST_WAIT) || (state_q == ST_LAST)) && !write_q)
                    ? mem[word_q] : '0;

`ifdef AHB_SLAVE_SRAM_ERR_EN
  assign HREADYOUT_o = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign HRESP_o     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  assign HREADYOUT_o = (state_q != ST_WAIT);
  assign HRESP_o     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_sram.sv
module tb_ahb_slave_sram;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 1024;
  localparam int NB = DW / 8;
  localparam int LSB = 2;
  localparam int WS_A = 0;
  localparam int WS_B = 3;

  typedef struct {
    logic          sel;
    logic [1:0]    tr;
    logic          wr;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    logic          wr;
    logic          err;
    int            cycles;
    logic [DW-1:0] rdata;
    logic [DW-1:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cur;
  logic          hsel, hsel_a, hsel_b;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic          hwrite;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rdy_a, rdy_b, resp_a, resp_b;

  assign hsel_a = hsel & ~cur;
  assign hsel_b = hsel & cur;

  ahb_slave_sram #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS_A)) u_a (
    .HCLK(clk), .HRESET(rst), .HSEL_i(hsel_a), .HTRANS_i(htrans), .HSIZE_i(hsize),
    .HWRITE_i(hwrite), .HADDR_i(haddr), .HWDATA_i(hwdata), .HREADY_i(rdy_a),
    .HRDATA_o(rdata_a), .HREADYOUT_o(rdy_a), .HRESP_o(resp_a));

  ahb_slave_sram #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS_B)) u_b (
    .HCLK(clk), .HRESET(rst), .HSEL_i(hsel_b), .HTRANS_i(htrans), .HSIZE_i(hsize),
    .HWRITE_i(hwrite), .HADDR_i(haddr), .HWDATA_i(hwdata), .HREADY_i(rdy_b),
    .HRDATA_o(rdata_b), .HREADYOUT_o(rdy_b), .HRESP_o(resp_b));

  int tests = 0;
  int fails = 0;
  txn_t txq[$];
  exp_t sb[$];
  logic [DW-1:0] mdl [2][DEPTH];

  function automatic exp_t model(input txn_t t);
    exp_t e;
    logic [AW-1:0] idx_full;
    int idx, off, n;
    bit err;
    idx_full = t.addr >> LSB;
    off = int'(t.addr[LSB-1:0]);
    n = 1 << t.size;
    err = 0;
`ifdef AHB_SLAVE_SRAM_ERR_EN
    if (idx_full >= AW'(DEPTH) || int'(t.size) > LSB || (t.addr % n) != 0) err = 1;
`endif
    idx = int'(idx_full % DEPTH);
    e.wr = t.wr;
    e.err = err;
    e.cycles = err ? 2 : ((cur ? WS_B : WS_A) + 1);
    e.rdata = '0;
    e.wdata = t.data;
    if (!err) begin
      if (t.wr) begin
        for (int b = 0; b < NB; b++)
          if (b >= off && b < off + n) mdl[int'(cur)][idx][8*b +: 8] = t.data[8*b +: 8];
      end else begin
        e.rdata = mdl[int'(cur)][idx];
      end
    end
    return e;
  endfunction

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] size,
                     input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.sel = 1'b1; t.tr = tr; t.wr = wr; t.size = size; t.addr = addr; t.data = data;
    txq.push_back(t);
  endtask

  // Pipelined master: a new address phase is driven at every negedge where the
  // bus is ready, so it overlaps the last cycle of the previous data phase.
  task automatic run_seq(input string tag);
    txn_t t;
    exp_t e;
    bit dp_valid, pend;
    int cyc, budget;
    logic rdy, rsp;
    logic [DW-1:0] rd;
    dp_valid = 0; pend = 0; cyc = 0; budget = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        dp_valid = 1; pend = 0; cyc = 0;
        hwdata = sb[0].wdata;
      end
      rdy = cur ? rdy_b : rdy_a;
      rsp = cur ? resp_b : resp_a;
      rd  = cur ? rdata_b : rdata_a;
      if (dp_valid) begin
        cyc++;
        tests++;
        if (!rdy) begin
          if (rsp !== sb[0].err || cyc >= sb[0].cycles) begin
            fails++;
            $display("FAIL %s stall: resp=%b cycle=%0d, required resp=%b len=%0d", tag, rsp, cyc, sb[0].err, sb[0].cycles);
          end
        end else begin
          e = sb.pop_front();
          dp_valid = 0;
          if (rsp !== e.err || cyc != e.cycles || rd !== e.rdata) begin
            fails++;
            $display("FAIL %s done: resp=%b cycles=%0d rdata=%h, required resp=%b cycles=%0d rdata=%h",
                     tag, rsp, cyc, rd, e.err, e.cycles, e.rdata);
          end
        end
      end
      if (rdy) begin
        if (txq.size() > 0) begin
          t = txq.pop_front();
          hsel = t.sel; htrans = t.tr; hsize = t.size; hwrite = t.wr; haddr = t.addr;
          if (t.sel && t.tr[1]) begin
            sb.push_back(model(t));
            pend = 1;
          end
        end else begin
          hsel = 1'b0; htrans = 2'd0;
        end
      end
      if (!dp_valid && !pend && txq.size() == 0) break;
      budget++;
      if (budget > 400) begin
        tests++; fails++;
        $display("FAIL %s timeout: queued=%0d, required 0", tag, txq.size());
        txq.delete(); sb.delete();
        hsel = 1'b0; htrans = 2'd0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({rdy_a, resp_a, rdata_a} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_a: rdy=%b resp=%b rdata=%h, required 1 0 0", rdy_a, resp_a, rdata_a);
    end
    tests++;
    if ({rdy_b, resp_b, rdata_b} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL reset_b: rdy=%b resp=%b rdata=%h, required 1 0 0", rdy_b, resp_b, rdata_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic init_words(input int n);
    for (int w = 0; w < n; w++) add(2'd2, 1'b1, 3'd2, AW'(4 * w), $urandom());
  endtask

  task automatic test_back_to_back();
    cur = 1'b0;
    init_words(18);
    add(2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    add(2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
    add(2'd3, 1'b1, 3'd2, 32'h14, 32'h12345678);
    add(2'd3, 1'b0, 3'd2, 32'h14, 32'h0);
    add(2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq("b2b");
  endtask

  task automatic test_wait_states();
    cur = 1'b1;
    init_words(18);
    add(2'd2, 1'b1, 3'd2, 32'h0, 32'h0BADF00D);
    add(2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
    add(2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    add(2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq("wait");
  endtask

  task automatic test_byte_lanes();
    for (int d = 0; d < 2; d++) begin
      cur = d[0];
      add(2'd2, 1'b1, 3'd2, 32'h10, 32'h11223344);
      add(2'd2, 1'b1, 3'd0, 32'h13, 32'hAA000000);
      add(2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
      add(2'd2, 1'b1, 3'd2, 32'h18, 32'hFFFFFFFF);
      add(2'd2, 1'b1, 3'd1, 32'h18, 32'h00005566);
      add(2'd2, 1'b1, 3'd0, 32'h19, 32'h00007700);
      add(2'd2, 1'b0, 3'd2, 32'h18, 32'h0);
      run_seq("lanes");
    end
  endtask

  task automatic test_illegal();
    for (int d = 0; d < 2; d++) begin
      cur = d[0];
      add(2'd2, 1'b1, 3'd2, 32'h0, 32'hA5A5A5A5);
      add(2'd2, 1'b1, 3'd2, 32'h1000, 32'h5A5A5A5A);
      add(2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
      add(2'd2, 1'b0, 3'd1, 32'h1, 32'h0);
      add(2'd2, 1'b1, 3'd3, 32'h0, 32'h99887766);
      add(2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
      add(2'd2, 1'b1, 3'd2, 32'h2, 32'h13579BDF);
      add(2'd2, 1'b0, 3'd2, 32'h0, 32'h0);
      add(2'd2, 1'b0, 3'd2, 32'h1004, 32'h0);
      run_seq("illegal");
    end
  endtask

  task automatic test_no_transfer();
    txn_t t;
    cur = 1'b0;
    add(2'd1, 1'b1, 3'd2, 32'h10, 32'hFEEDFACE);
    add(2'd0, 1'b1, 3'd2, 32'h10, 32'hFEEDFACE);
    t.sel = 1'b0; t.tr = 2'd2; t.wr = 1'b1; t.size = 3'd2; t.addr = 32'h10; t.data = 32'hFEEDFACE;
    txq.push_back(t);
    add(2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
    run_seq("no_xfer");
  endtask

  task automatic test_reset_mid();
    cur = 1'b1;
    add(2'd2, 1'b1, 3'd2, 32'h40, 32'hCAFEF00D);
    run_seq("rst_pre_b");
    @(negedge clk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h12345678;
    tests++;
    if (rdy_b !== 1'b0) begin fails++; $display("FAIL rst_wait_pre: rdy=%b, required 0", rdy_b); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({rdy_b, resp_b, rdata_b} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL rst_wait: rdy=%b resp=%b rdata=%h, required 1 0 0", rdy_b, resp_b, rdata_b);
    end
    @(negedge clk);
    rst = 1'b0;
    add(2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
    run_seq("rst_post_b");

    cur = 1'b0;
    add(2'd2, 1'b1, 3'd2, 32'h44, 32'h0DDBA11E);
    run_seq("rst_pre_a");
    @(negedge clk);
    hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h44;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'd0; hwdata = 32'h87654321;
    rst = 1'b1;
    #1;
    tests++;
    if ({rdy_a, resp_a, rdata_a} !== {1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL rst_last: rdy=%b resp=%b rdata=%h, required 1 0 0", rdy_a, resp_a, rdata_a);
    end
    @(negedge clk);
    rst = 1'b0;
    add(2'd2, 1'b0, 3'd2, 32'h44, 32'h0);
    run_seq("rst_post_a");
  endtask

  task automatic test_random();
    int sz, off;
    for (int d = 0; d < 2; d++) begin
      cur = d[0];
      init_words(8);
      for (int i = 0; i < 40; i++) begin
        sz = $urandom_range(0, 2);
        off = $urandom_range(0, 3) & ~((1 << sz) - 1);
        add(($urandom_range(0, 7) == 0) ? 2'd1 : (($urandom_range(0, 1) != 0) ? 2'd3 : 2'd2),
            1'($urandom_range(0, 1)), 3'(sz), AW'(4 * $urandom_range(0, 7) + off), $urandom());
      end
      for (int w = 0; w < 8; w++) add(2'd2, 1'b0, 3'd2, AW'(4 * w), 32'h0);
      run_seq("random");
    end
  endtask

  initial begin
    cur = 1'b0; hsel = 1'b0; htrans = 2'd0; hsize = 3'd2; hwrite = 1'b0;
    haddr = '0; hwdata = '0; rst = 1'b1;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_byte_lanes();
    test_illegal();
    test_no_transfer();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ahb_slave_sram.md
# ahb_slave_sram

AHB-Lite responder that terminates one slave port of the AHB interconnect with a word-organised SRAM array. Decodes address-phase signals, inserts a parameterised number of wait states, performs byte-lane-masked writes and combinational-array reads, and returns the two-cycle ERROR response for illegal accesses. Standard slave-side endpoint for bus bring-up, interconnect verification and on-chip scratch memory.

## Interface
- HADDR_WIDTH, 32, address bus width
- HDATA_WIDTH, 32, data bus width; 32 or 64 only
- MEM_DEPTH, 1024, number of HDATA_WIDTH-bit words; power of two
- WAIT_STATES, 0, wait cycles inserted per OKAY data phase; 0..15

Ports:
- HCLK  in  1  bus clock, all logic on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL_i  in  1  slave select from interconnect decode
- HTRANS_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HSIZE_i  in  3  transfer size, 0=byte, 1=half, 2=word, 3=dword
- HWRITE_i  in  1  1=write
- HADDR_i  in  HADDR_WIDTH  byte address
- HWDATA_i  in  HDATA_WIDTH  write data, valid in data phase
- HREADY_i  in  1  bus-level HREADY (previous transfer complete)
- HRDATA_o  out  HDATA_WIDTH  read data
- HREADYOUT_o  out  1  this slave's ready
- HRESP_o  out  1  0=OKAY, 1=ERROR

## Operation
- Accept = HSEL_i & HTRANS_i[1] & HREADY_i. On accept, register addr, size, write into data-phase regs. IDLE/BUSY or unselected: no transfer; next data phase completes OKAY, zero wait.
- Illegal access (accept with any of): word index HADDR_i >> log2(HDATA_WIDTH/8) >= MEM_DEPTH; HSIZE_i > log2(HDATA_WIDTH/8); address not aligned to size.
- FSM states:
  - IDLE: HREADYOUT_o=1, HRESP_o=0. Accept → illegal ? ERR1 : (WAIT_STATES>0 ? WAIT with cnt=WAIT_STATES-1 : LAST).
  - WAIT: HREADYOUT_o=0, HRESP_o=0; cnt==0 → LAST else cnt-1.
  - LAST: HREADYOUT_o=1, HRESP_o=0; write commits at the closing edge; accept → dispatch as IDLE, else IDLE.
  - ERR1: HREADYOUT_o=0, HRESP_o=1 → ERR2.
  - ERR2: HREADYOUT_o=1, HRESP_o=1; accept → dispatch as IDLE, else IDLE.
- Counter width clog2(WAIT_STATES+1), minimum 1.
- Write: lanes = (1<<(1<<size))-1 shifted left by addr low bits, little-endian; only enabled bytes of mem[word] updated from HWDATA_i. Illegal accesses never write.
- Read: HRDATA_o = mem[word_q] during WAIT/LAST of a read; 0 in all other states, including ERR1/ERR2.
- Memory contents not reset; unwritten words read X in simulation.

## Timing
- Reset values: HREADYOUT_o=1, HRESP_o=0, HRDATA_o=0, state IDLE, cnt=0.
- OKAY latency: data phase = WAIT_STATES+1 cycles after the address-phase cycle.
- Error: exactly 2 data-phase cycles, independent of WAIT_STATES.
- Back-to-back: address phase of transfer N+1 overlaps the LAST/ERR2 cycle of N; no bubble.
- Read-after-write same word, consecutive transfers: read returns newly written data (write commits at the edge the read address is registered).
- Reset during WAIT/LAST: pending write discarded, outputs return to reset values immediately.
- Address-phase inputs ignored while HREADY_i=0.

## Configuration
- AHB_SLAVE_SRAM_ERR_EN defined: illegal-access checks and ERR1/ERR2 present as above.
- Not defined: no checks, HRESP_o tied 0, ERR states absent; word index = address word bits modulo MEM_DEPTH; misaligned access uses the computed lane mask unchanged (truncated to bus width).

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back → HREADYOUT_o stays 1, read data 0xDEADBEEF in the cycle after the read address phase.
- WAIT_STATES=3: read 0x0 → HREADYOUT_o low 3 cycles, high on the 4th with data valid and HRESP_o=0.
- Byte write 0xAA to 0x13 over word 0x11223344 → read 0x10 returns 0xAA223344.
- ERR_EN, MEM_DEPTH=1024: write to 0x1000 → HRESP_o=1 for 2 cycles, HREADYOUT_o 0 then 1; subsequent read of 0x0 unchanged.
- ERR_EN: halfword read at 0x01 → ERROR; without ERR_EN → OKAY, no error states.
- Assert HRESET during WAIT of a write → HREADYOUT_o=1 next sample, target word unchanged.
